// File: rtl/fetch.sv
// Instruction fetch front end: PC sequencing, one-cycle-latency imem requests and a small FIFO to decode.
// Optional perf counters (fetch_count, stall_count) are built only when FETCH_PERF_CNT_EN is defined.
module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc_out,
  output logic [31:0] command,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  logic [31:0]   pc_buf  [BUF_DEPTH];
  logic [31:0]   cmd_buf [BUF_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [31:0]   fetch_pc;
  logic [31:0]   last_pc;
  logic [31:0]   last_cmd;
  logic          pop;
  logic          push;
  logic          issue;
  logic [OW-1:0] occupancy;

  // Occupancy counts slots already promised: buffered entries plus the response still in flight.
  always_comb begin
    out_valid = rstn && (count != '0) && !redirect;
    pop       = out_valid && out_ready;
    push      = rstn && inflight && !redirect;
    occupancy = OW'(count) + OW'(inflight) - OW'(pop);
    issue     = rstn && (redirect || (occupancy < OW'(BUF_DEPTH)));
    imem_en   = issue;
    imem_addr = redirect ? redirect_pc : fetch_pc;
    pc_out    = 32'h0;
    command   = 32'h0;
    if (rstn) begin
      pc_out  = (count != '0) ? pc_buf[rd_ptr]  : last_pc;
      command = (count != '0) ? cmd_buf[rd_ptr] : last_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      last_pc     <= 32'h0;
      last_cmd    <= 32'h0;
    end else begin
      last_pc  <= pc_out;
      last_cmd <= command;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= imem_addr;
        fetch_pc    <= imem_addr + 32'd4;
      end
      if (redirect) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_buf[wr_ptr]  <= inflight_pc;
      cmd_buf[wr_ptr] <= imem_data;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      if (pop)                     fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (out_valid && !out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign fetch_count = 32'h0;
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch.sv
// Randomized + directed bench for fetch against a queue-based transaction model.
module tb_fetch;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC1  = 32'h0000_0000;
  localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_ready = 1'b1;
  logic        imem_en, imem_en2;
  logic [31:0] imem_addr, imem_addr2;
  logic [31:0] imem_data = 32'h0, imem_data2 = 32'h0;
  logic        out_valid, out_valid2;
  logic [31:0] pc_out, pc_out2, command, command2;
  logic [31:0] fetch_count, stall_count, fetch_count2, stall_count2;

  always #5 clk = ~clk;

  fetch #(.RESET_PC(RPC1), .BUF_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rstn(rstn), .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .command(command), .fetch_count(fetch_count), .stall_count(stall_count));

  fetch #(.RESET_PC(RPC2), .BUF_DEPTH(DEPTH)) u_dut2 (
    .clk(clk), .rstn(rstn), .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid2), .out_ready(out_ready),
    .pc_out(pc_out2), .command(command2), .fetch_count(fetch_count2), .stall_count(stall_count2));

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // Instruction memories: data for a request appears during the following cycle.
  always @(posedge clk) imem_data  <= imem_en  ? mem_f(imem_addr)  : 32'hDEAD_BEEF;
  always @(posedge clk) imem_data2 <= imem_en2 ? mem_f(imem_addr2) : 32'hDEAD_BEEF;

  int total = 0;
  int bad   = 0;
  bit chk2  = 1'b1;

  logic [31:0] mq[$];
  bit          m_inf;
  logic [31:0] m_inf_pc, m_fpc, m_last, m_last_cmd, m_fc, m_sc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    logic        ev, epop, eiss;
    logic [31:0] epc, ecmd, eaddr;
    @(negedge clk);
    rstn = r; redirect = rd; redirect_pc = rpc; out_ready = rdy;
    #1;
    if (!r) begin
      ev = 1'b0; epop = 1'b0; eiss = 1'b0; epc = 32'h0; ecmd = 32'h0; eaddr = 32'h0;
    end else begin
      ev   = (mq.size() != 0) && !rd;
      epc  = (mq.size() != 0) ? mq[0] : m_last;
      ecmd = (mq.size() != 0) ? mem_f(mq[0]) : m_last_cmd;
      epop = ev && rdy;
      eiss = rd || ((mq.size() + int'(m_inf) - int'(epop)) < DEPTH);
      eaddr = rd ? rpc : m_fpc;
    end
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("imem_en", 32'(imem_en), 32'(eiss));
    if (eiss) chk("imem_addr", imem_addr, eaddr);
    chk("pc_out", pc_out, epc);
    chk("command", command, ecmd);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", fetch_count, r ? m_fc : 32'h0);
    chk("stall_count", stall_count, r ? m_sc : 32'h0);
`else
    chk("fetch_count", fetch_count, 32'h0);
    chk("stall_count", stall_count, 32'h0);
`endif
    if (chk2) begin
      chk("dut2_valid", 32'(out_valid2), 32'(ev));
      if (ev) begin
        chk("dut2_pc", pc_out2, epc + RPC2);
        chk("dut2_command", command2, mem_f(epc + RPC2));
      end
    end
    if (!r) begin
      mq.delete(); m_inf = 1'b0; m_inf_pc = 32'h0; m_fpc = RPC1;
      m_last = 32'h0; m_last_cmd = 32'h0; m_fc = 32'h0; m_sc = 32'h0;
    end else begin
      if (ev && rdy)  m_fc = m_fc + 32'd1;
      if (ev && !rdy) m_sc = m_sc + 32'd1;
      m_last = epc; m_last_cmd = ecmd;
      if (rd) mq.delete();
      else begin
        if (epop) void'(mq.pop_front());
        if (m_inf) mq.push_back(m_inf_pc);
      end
      if (eiss) begin
        m_inf_pc = eaddr;
        m_fpc    = eaddr + 32'd4;
      end
      m_inf = eiss;
    end
  endtask

  initial begin
    m_inf = 1'b0; m_inf_pc = 32'h0; m_fpc = RPC1;
    m_last = 32'h0; m_last_cmd = 32'h0; m_fc = 32'h0; m_sc = 32'h0;

    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Release: 0x0, 0x4, 0x8 back to back; second instance starts at 0xFFFF_FFF8 and wraps.
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (6) step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);
    chk2 = 1'b0;

    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0100, 1'b1);
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);

    step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0300, 1'b1);
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);

    step(1'b1, 1'b1, 32'hFFFF_FFF4, 1'b1);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0);

    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (13) step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 63) != 0),
           1'($urandom_range(0, 11) == 0),
           $urandom() & 32'hFFFF_FFFC,
           1'($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
